// File: rtl/alu_pkg.sv
// Shared ALU definitions: unit select encodings, flag struct and flag bit positions.
package alu_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    SEL_ARITH = 2'd0,
    SEL_LOGIC = 2'd1,
    SEL_SHIFT = 2'd2,
    SEL_PASS  = 2'd3
  } alu_sel_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V derivation from a selected ALU result and its producing unit.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] result,
  input  logic [1:0]       sel,
  input  logic             carry,
  input  logic             overflow,
  output alu_flags_t       flags
);

  always_comb begin
    flags   = '0;
    flags.n = result[WIDTH-1];
    flags.z = (result == '0);
    // Only the adder and shifter produce a meaningful carry; only the adder overflows.
    if (sel == SEL_ARITH) begin
      flags.c = carry;
      flags.v = overflow;
    end else if (sel == SEL_SHIFT) begin
      flags.c = carry;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flag capture, 2-entry skid buffer on valid/ready, sticky overflow.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [1:0]       in_sel,
  input  logic             in_carry,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             sticky_ovf,
  input  logic             sticky_clr,
  output logic [1:0]       occupancy
);

  alu_flags_t       in_flags;

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_result_q, main_result_d;
  alu_flags_t       main_flags_q, main_flags_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_result_q, skid_result_d;
  alu_flags_t       skid_flags_q, skid_flags_d;
  logic             sticky_q, sticky_d;
  logic [1:0]       occupancy_q, occupancy_d;

  logic             accept;
  logic             drain;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result   (in_result),
    .sel      (in_sel),
    .carry    (in_carry),
    .overflow (in_overflow),
    .flags    (in_flags)
  );

  // Ready depends only on registered state and reset, never on out_ready.
  assign in_ready = !rst && !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid_q && out_ready;

  always_comb begin
    main_valid_d  = main_valid_q;
    main_result_d = main_result_q;
    main_flags_d  = main_flags_q;
    skid_valid_d  = skid_valid_q;
    skid_result_d = skid_result_q;
    skid_flags_d  = skid_flags_q;

    if (drain) begin
      if (skid_valid_q) begin
        main_result_d = skid_result_q;
        main_flags_d  = skid_flags_q;
        skid_valid_d  = 1'b0;
      end else begin
        main_valid_d  = 1'b0;
      end
    end

    // accept implies skid is empty, so the incoming beat never collides with a skid-to-main move.
    if (accept) begin
      if (!main_valid_q || drain) begin
        main_valid_d  = 1'b1;
        main_result_d = in_result;
        main_flags_d  = in_flags;
      end else begin
        skid_valid_d  = 1'b1;
        skid_result_d = in_result;
        skid_flags_d  = in_flags;
      end
    end

    sticky_d    = (sticky_q && !sticky_clr) || (drain && main_flags_q.v);
    occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q  <= 1'b0;
      main_result_q <= '0;
      main_flags_q  <= '0;
      skid_valid_q  <= 1'b0;
      skid_result_q <= '0;
      skid_flags_q  <= '0;
      sticky_q      <= 1'b0;
      occupancy_q   <= 2'd0;
    end else begin
      main_valid_q  <= main_valid_d;
      main_result_q <= main_result_d;
      main_flags_q  <= main_flags_d;
      skid_valid_q  <= skid_valid_d;
      skid_result_q <= skid_result_d;
      skid_flags_q  <= skid_flags_d;
      sticky_q      <= sticky_d;
      occupancy_q   <= occupancy_d;
    end
  end

  assign out_valid  = main_valid_q;
  assign out_result = main_result_q;
  assign out_flags  = main_flags_q;
  assign sticky_ovf = sticky_q;
  assign occupancy  = occupancy_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed vectors plus a long random valid/ready run.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [1:0]  in_sel;
  logic        in_carry;
  logic        in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic        sticky_ovf;
  logic        sticky_clr;
  logic [1:0]  occupancy;

  int          errors = 0;
  int          checks = 0;
  logic [19:0] exp_q[$];
  bit          rand_ready = 0;

  alu_result_stage #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_sel      (in_sel),
    .in_carry    (in_carry),
    .in_overflow (in_overflow),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .sticky_ovf  (sticky_ovf),
    .sticky_clr  (sticky_clr),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference flags written from the flag rules, independent of the RTL.
  function automatic logic [3:0] model_flags(input logic [15:0] r, input logic [1:0] s,
                                             input logic c, input logic o);
    logic n_f, z_f, c_f, v_f;
    n_f = r[15];
    z_f = (r == 16'h0000);
    c_f = (s == 2'd0 || s == 2'd2) ? c : 1'b0;
    v_f = (s == 2'd0) ? o : 1'b0;
    return {n_f, z_f, c_f, v_f};
  endfunction

  task automatic send(input logic [15:0] r, input logic [1:0] s, input logic c,
                      input logic o, input logic [3:0] ef);
    int n;
    n = 0;
    in_valid = 1'b1; in_result = r; in_sel = s; in_carry = c; in_overflow = o;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accept_within_1000");
    end else begin
      exp_q.push_back({r, ef});
    end
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Monitor: every delivered beat is checked against the head of the scoreboard.
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", {out_result, out_flags});
        end else begin
          e = exp_q.pop_front();
          chk("beat_result", {16'h0, out_result}, {16'h0, e[19:4]});
          chk("beat_flags", {28'h0, out_flags}, {28'h0, e[3:0]});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int waited;
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_sel = '0; in_carry = 0;
    in_overflow = 0; out_ready = 1'b0; sticky_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_result", {16'h0, out_result}, 32'h0);
    chk("rst_out_flags", {28'h0, out_flags}, 32'h0);
    chk("rst_sticky", {31'h0, sticky_ovf}, 32'h0);
    chk("rst_occupancy", {30'h0, occupancy}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
    step();

    // Single zero LOGIC beat: carry must be masked.
    send(16'h0000, 2'd1, 1'b1, 1'b0, 4'b0100);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat1_out_valid", {31'h0, out_valid}, 32'h1);
    chk("lat1_occupancy", {30'h0, occupancy}, 32'h1);
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("drained_occupancy", {30'h0, occupancy}, 32'h0);
    step();

    // Streaming with out_ready high.
    send(16'h8000, 2'd0, 1'b1, 1'b1, 4'b1011);
    send(16'h0001, 2'd2, 1'b1, 1'b0, 4'b0010);
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_occupancy", {30'h0, occupancy}, 32'h1);
    step();
    @(negedge clk);
    chk("sticky_after_v", {31'h0, sticky_ovf}, 32'h1);
    step();
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", {31'h0, sticky_ovf}, 32'h0);
    step();

    // Clear and V=1 delivery in the same cycle: set wins.
    out_ready = 1'b0;
    send(16'h0000, 2'd0, 1'b0, 1'b1, 4'b0101);
    in_valid = 1'b0;
    sticky_clr = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("sticky_set_wins", {31'h0, sticky_ovf}, 32'h1);
    step();
    @(negedge clk);
    chk("sticky_clr_alone", {31'h0, sticky_ovf}, 32'h0);
    step();
    sticky_clr = 1'b0;

    // Back-pressure: A, B absorbed, C held until out_ready returns.
    out_ready = 1'b0;
    send(16'h1234, 2'd1, 1'b1, 1'b0, 4'b0000);
    send(16'hFFFF, 2'd3, 1'b1, 1'b1, 4'b1000);
    in_result = 16'h7FFF; in_sel = 2'd0; in_carry = 1'b0; in_overflow = 1'b1;
    @(negedge clk);
    chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
    chk("bp_occupancy", {30'h0, occupancy}, 32'h2);
    @(negedge clk);
    chk("bp_in_ready_held", {31'h0, in_ready}, 32'h0);
    chk("bp_out_result_held", {16'h0, out_result}, 32'h1234);
    step();
    out_ready = 1'b1;
    send(16'h7FFF, 2'd0, 1'b0, 1'b1, 4'b0001);
    in_valid = 1'b0;
    repeat (4) step();

    // Reset while full discards both entries.
    out_ready = 1'b0;
    send(16'hAAAA, 2'd1, 1'b0, 1'b0, 4'b1000);
    send(16'h5555, 2'd1, 1'b0, 1'b0, 4'b0000);
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_occupancy", {30'h0, occupancy}, 32'h2);
    step();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_in_ready", {31'h0, in_ready}, 32'h0);
    step();
    @(negedge clk);
    chk("rst_mid_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_mid_occupancy", {30'h0, occupancy}, 32'h0);
    chk("rst_mid_out_result", {16'h0, out_result}, 32'h0);
    chk("rst_mid_in_ready2", {31'h0, in_ready}, 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_release", {31'h0, in_ready}, 32'h1);
    step();

    // Random valid/ready traffic.
    rand_ready = 1;
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] r;
      logic [1:0]  s;
      logic        c, o;
      r = 16'($urandom());
      if ($urandom_range(0, 7) == 0) r = 16'h0000;
      s = 2'($urandom_range(0, 3));
      c = 1'($urandom_range(0, 1));
      o = 1'($urandom_range(0, 1));
      send(r, s, c, o, model_flags(r, s, c, o));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b0;
    rand_ready = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the ALU result multiplexer. It captures the 16-bit selected result together with its unit select and raw carry/overflow. It derives the N/Z/C/V flags and presents {result, flags} on a valid/ready interface through a 2-entry skid buffer, so back-pressure from the consumer never corrupts or drops a result. It also keeps a sticky overflow status bit for software/status logic.

## Interface
- WIDTH, 16, result width; flag rules below assume MSB = sign bit.
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  mux output holds a result to be captured.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
- in_result  in  WIDTH  selected result from the result mux.
- in_sel  in  2  unit select that produced in_result (alu_pkg SEL_ARITH/SEL_LOGIC/SEL_SHIFT/SEL_PASS).
- in_carry  in  1  carry-out of arithmetic unit, or last bit shifted out of shift unit.
- in_overflow  in  1  signed overflow from arithmetic unit.
- out_valid  out  1  out_result/out_flags hold a valid beat.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- out_result  out  WIDTH  registered result.
- out_flags  out  4  {N, Z, C, V}.
- sticky_ovf  out  1  set by any delivered beat with V=1; held until cleared.
- sticky_clr  in  1  clears sticky_ovf.
- occupancy  out  2  entries held: 0, 1 or 2.

## Operation
- Flags are computed at capture and stored with the result. Z = (in_result == 0). N = in_result[WIDTH-1].
- C = in_carry for SEL_ARITH or SEL_SHIFT; 0 for SEL_LOGIC and SEL_PASS.
- V = in_overflow for SEL_ARITH; 0 otherwise.
- The stage has two storage entries, each holding {result, flags}. The main entry drives the outputs. The skid entry holds one overflow beat.
- Accept with main empty, or main draining this cycle with skid empty: the beat goes to main.
- Accept while main is full and not draining: the beat goes to skid.
- Drain of main while skid is full: skid moves into main, and skid is emptied.
- Simultaneous accept and drain with skid full cannot occur, because in_ready = 0 then.
- in_ready = !skid_full, registered-state based with no combinational path from out_ready. in_ready is forced 0 while rst = 1.
- Beats are delivered strictly in acceptance order. None are dropped or duplicated.
- out_result/out_flags stay stable while out_valid && !out_ready.
- Sticky: set when out_valid && out_ready && V. Cleared by sticky_clr. If set and clear occur in the same cycle, set wins.
- Reset mid-operation: both entries are discarded, and any in-flight beat is lost by design.
- Reset values: out_valid=0, out_result=0, out_flags=0, sticky_ovf=0, occupancy=0, in_ready=0 during reset and 1 on the first cycle after.

## Timing
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k, i.e. 1 cycle.
- Throughput: 1 beat/cycle when out_ready is held high. occupancy stays ≤1.
- out_ready low for n cycles with continuous in_valid: 2 beats are absorbed, and in_ready drops the cycle after the skid fills.
- After out_ready rises, in_ready returns to 1 the cycle after skid empties.
- All outputs are registered except in_ready, which decodes registered state and rst only.

## Structure
- alu_pkg:
  - reuses the existing SEL_* encodings;
  - adds the alu_flags_t packed struct {n, z, c, v};
  - adds the FLAG_N/FLAG_Z/FLAG_C/FLAG_V bit-index constants.
- One sub-module, alu_flag_gen. It is combinational and derives alu_flags_t from result, sel, carry and overflow, so the decoder and verification models can reuse it.
- Top-level alu_result_stage contains the skid-buffer control, the two entries and the sticky register.

## Test plan
- Reset, then a single beat in_result=16'h0000, sel=SEL_LOGIC, carry=1 → one cycle later out_result=0, out_flags=4'b0100 (C masked), occupancy=1.
- Streaming 16'h8000 ARITH carry=1 ovf=1, then 16'h0001 SHIFT carry=1, with out_ready=1 → out_flags 4'b1011 then 4'b0010, and sticky_ovf=1 after the first delivery.
- out_ready=0 with 3 back-to-back in_valid beats A, B, C → A and B accepted, in_ready=0 while C is held, occupancy=2. After out_ready=1, the order delivered is A, B, C with no loss.
- sticky_clr and a V=1 delivery in the same cycle → sticky_ovf=1. sticky_clr alone the next cycle → 0.
- rst asserted with occupancy=2 → next cycle out_valid=0, occupancy=0, out_result=0, in_ready=0. After rst is released, in_ready=1.
- Random valid/ready toggling over 10k beats vs a scoreboard → exact order, and flags match the alu_flag_gen model.
